// File: rtl/cache_pkg.sv
// Shared definitions for the cache sequencing controller: widths, FSM
// encoding and address field helpers.
package cache_pkg;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 3;
  localparam int INDEX_W  = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NUM_SETS = 1 << INDEX_W;
  localparam int LINE_W   = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_EVAL   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W+INDEX_W];
  endfunction

  // One-hot set select for a given index.
  function automatic logic [NUM_SETS-1:0] set_sel(input logic [INDEX_W-1:0] idx);
    logic [NUM_SETS-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// Request/response handshake plus the shared cache_set bus.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; the source holds its payload and valid stable until that edge.
interface cache_ctrl_if;
  import cache_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  logic [ADDR_W-1:0]          req_addr;
  logic [LINE_W-1:0]          req_wdata;
  logic                       resp_valid;
  logic                       resp_ready;
  logic                       resp_hit;
  logic [LINE_W-1:0]          resp_data;
  logic                       set_state;
  logic [TAG_W-1:0]           set_tag;
  logic [LINE_W-1:0]          set_wdata;
  logic                       set_mem_write;
  logic [NUM_SETS-1:0]        set_enable;
  logic [NUM_SETS-1:0]        set_hit;
  logic [NUM_SETS*LINE_W-1:0] set_rdata;

  // Controller side.
  modport slave (
    input  req_valid, req_addr, req_wdata, resp_ready, set_hit, set_rdata,
    output req_ready, resp_valid, resp_hit, resp_data,
           set_state, set_tag, set_wdata, set_mem_write, set_enable
  );

  // Requester / set-array side.
  modport master (
    output req_valid, req_addr, req_wdata, resp_ready, set_hit, set_rdata,
    input  req_ready, resp_valid, resp_hit, resp_data,
           set_state, set_tag, set_wdata, set_mem_write, set_enable
  );
endinterface

// File: rtl/cache_stats.sv
// Saturating hit/miss/access counters with synchronous active-low clear.
module cache_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_hit,
  input  logic             inc_miss,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] access_count
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count    <= '0;
      miss_count   <= '0;
      access_count <= '0;
    end else begin
      if (inc_hit && hit_count != CNT_MAX)
        hit_count <= hit_count + CNT_ONE;
      if (inc_miss && miss_count != CNT_MAX)
        miss_count <= miss_count + CNT_ONE;
      if ((inc_hit || inc_miss) && access_count != CNT_MAX)
        access_count <= access_count + CNT_ONE;
    end
  end
endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller: one reference at a time through search, evaluate,
// update and response phases of the addressed cache_set.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_ctrl_if.slave      bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] access_count,
  output state_t           fsm_state
);
  state_t              state;
  logic [INDEX_W-1:0]  idx;
  logic                hit_r;
  logic [LINE_W-1:0]   data_r;
  logic                sel_hit;
  logic [LINE_W-1:0]   sel_data;
  logic                inc_hit;
  logic                inc_miss;

  // Only the addressed set's hit flag and data matter.
  assign sel_hit   = bus.set_hit[idx];
  assign sel_data  = bus.set_rdata[int'(idx)*LINE_W +: LINE_W];
  assign inc_hit   = (state == ST_UPDATE) && hit_r;
  assign inc_miss  = (state == ST_UPDATE) && !hit_r;
  assign fsm_state = state;

  // FSM with registered bus and response outputs; each branch sets up the
  // outputs for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      idx               <= '0;
      hit_r             <= 1'b0;
      data_r            <= '0;
      bus.req_ready     <= 1'b0;
      bus.resp_valid    <= 1'b0;
      bus.resp_hit      <= 1'b0;
      bus.resp_data     <= '0;
      bus.set_state     <= 1'b0;
      bus.set_tag       <= '0;
      bus.set_wdata     <= '0;
      bus.set_mem_write <= 1'b0;
      bus.set_enable    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            idx            <= addr_index(bus.req_addr);
            bus.set_tag    <= addr_tag(bus.req_addr);
            bus.set_wdata  <= bus.req_wdata;
            bus.set_enable <= set_sel(addr_index(bus.req_addr));
            bus.set_state  <= 1'b0;
            bus.req_ready  <= 1'b0;
            state          <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          hit_r             <= sel_hit;
          data_r            <= sel_data;
          // Update phase always runs so the set drops its hit flag; only a
          // miss selects the set and pushes the new line.
          bus.set_state     <= 1'b1;
          bus.set_enable    <= sel_hit ? '0 : set_sel(idx);
          bus.set_mem_write <= !sel_hit;
          state             <= ST_UPDATE;
        end
        ST_UPDATE: begin
          bus.set_state     <= 1'b0;
          bus.set_enable    <= '0;
          bus.set_mem_write <= 1'b0;
          bus.resp_valid    <= 1'b1;
          bus.resp_hit      <= hit_r;
          bus.resp_data     <= hit_r ? data_r : '0;
          state             <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.resp_hit   <= 1'b0;
            bus.resp_data  <= '0;
            bus.req_ready  <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  cache_stats #(.CNT_W(CNT_W)) u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc_hit      (inc_hit),
    .inc_miss     (inc_miss),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .access_count (access_count)
  );
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed and random bench for cache_ctrl with a response scoreboard and a
// narrow counter width so saturation is reachable.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] access_count;
  state_t        fsm_state;

  cache_ctrl_if bus();

  cache_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .access_count (access_count),
    .fsm_state    (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [64:0] exp_q[$];
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int exp_hit   = 0;
  int exp_miss  = 0;
  int exp_acc   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_hit_count"},    hit_count,    exp_hit);
    check({tag, "_miss_count"},   miss_count,   exp_miss);
    check({tag, "_access_count"}, access_count, exp_acc);
  endtask

  // Driver: one full reference, checking every phase; bp = cycles of
  // response backpressure with a second request held on req_valid.
  task automatic do_req(input logic [31:0] addr, input logic [63:0] wdata, input int bp);
    logic [INDEX_W-1:0]  i;
    logic [TAG_W-1:0]    t;
    logic [NUM_SETS-1:0] sel;
    logic                eh;
    logic [63:0]         ed;
    logic [64:0]         exp_resp;
    int                  waited;
    i   = addr[4:3];
    t   = addr[31:5];
    sel = 4'b0001 << i;
    eh  = bus.set_hit[i];
    ed  = eh ? bus.set_rdata[int'(i)*64 +: 64] : 64'd0;

    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    check("req_ready_wait", bus.req_ready, 1'b1);

    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    exp_q.push_back({eh, ed});
    step();
    bus.req_valid = 1'b0;
    check("search_state",  fsm_state,      ST_SEARCH);
    check("search_enable", bus.set_enable, sel);
    check("search_phase",  bus.set_state,  1'b0);
    check("search_tag",    bus.set_tag,    t);
    check("search_ready",  bus.req_ready,  1'b0);

    step();
    check("eval_state",  fsm_state,      ST_EVAL);
    check("eval_enable", bus.set_enable, sel);
    check("eval_phase",  bus.set_state,  1'b0);

    step();
    check("upd_state",  fsm_state,         ST_UPDATE);
    check("upd_phase",  bus.set_state,     1'b1);
    check("upd_enable", bus.set_enable,    eh ? 4'b0000 : sel);
    check("upd_write",  bus.set_mem_write, !eh);
    check("upd_wdata",  bus.set_wdata,     wdata);

    step();
    exp_acc = sat_inc(exp_acc);
    if (eh) exp_hit = sat_inc(exp_hit);
    else    exp_miss = sat_inc(exp_miss);
    check("resp_valid", bus.resp_valid, 1'b1);
    check("resp_ready_low", bus.req_ready, 1'b0);
    check("resp_idle_bus", {bus.set_enable, bus.set_mem_write, bus.set_state}, 6'd0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
      exp_resp = '0;
    end else begin
      exp_resp = exp_q.pop_front();
    end
    check("resp_payload", {bus.resp_hit, bus.resp_data}, exp_resp);
    check_counters("resp");

    for (int k = 0; k < bp; k++) begin
      bus.req_valid = 1'b1;
      step();
      check("bp_valid",   bus.resp_valid, 1'b1);
      check("bp_payload", {bus.resp_hit, bus.resp_data}, exp_resp);
      check("bp_ready",   bus.req_ready, 1'b0);
      check("bp_access",  access_count, exp_acc);
    end

    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check("done_valid",  bus.resp_valid, 1'b0);
    check("done_ready",  bus.req_ready,  1'b1);
    check("done_state",  fsm_state,      ST_IDLE);
    check("done_access", access_count,   exp_acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  bus.req_ready,     1'b0);
    check({tag, "_resp"},       {bus.resp_valid, bus.resp_hit, bus.resp_data}, 66'd0);
    check({tag, "_enable"},     bus.set_enable,    4'b0000);
    check({tag, "_mem_write"},  bus.set_mem_write, 1'b0);
    check({tag, "_phase"},      bus.set_state,     1'b0);
    check({tag, "_tag"},        bus.set_tag,       27'd0);
    check({tag, "_wdata"},      bus.set_wdata,     64'd0);
    check_counters(tag);
  endtask

  // Directed sequence followed by random references.
  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus.set_hit    = '0;
    bus.set_rdata  = '0;

    // Reset then idle
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    check("post_reset_ready", bus.req_ready, 1'b1);
    check("post_reset_state", fsm_state, ST_IDLE);
    check_counters("post_reset");

    // Cold miss: sets hold distinct non-zero data that must not leak out.
    for (int k = 0; k < NUM_SETS; k++)
      bus.set_rdata[k*64 +: 64] = 64'hAAAA_0000_0000_0000 | 64'(k + 1);
    bus.set_hit = 4'b0000;
    do_req(32'h0000_0040, 64'hDEAD_BEEF_0000_0001, 0);

    // Hit on set 2
    bus.set_hit = 4'b0100;
    bus.set_rdata[2*64 +: 64] = 64'h0000_0000_0000_1234;
    do_req(32'h0000_0050, 64'h1111_2222_3333_4444, 0);

    // Cross-set mask: only set 3 hits, reference goes to set 1
    bus.set_hit = 4'b1000;
    do_req(32'h0000_0048, 64'h5555_6666_7777_8888, 0);

    // Backpressure on a hit
    bus.set_hit = 4'b0010;
    bus.set_rdata[1*64 +: 64] = 64'hCAFE_F00D_0BAD_BEEF;
    do_req(32'hFFFF_FFC8, 64'h0123_4567_89AB_CDEF, 5);

    // Mid-op reset during EVAL
    bus.set_hit   = 4'b1111;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1234_5658;
    bus.req_wdata = 64'h9999_AAAA_BBBB_CCCC;
    step();
    bus.req_valid = 1'b0;
    step();
    check("midrst_eval", fsm_state, ST_EVAL);
    rst_n = 1'b0;
    step();
    exp_hit  = 0;
    exp_miss = 0;
    exp_acc  = 0;
    check("midrst_state", fsm_state, ST_IDLE);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("midrst_no_resp", bus.resp_valid, 1'b0);
    end
    check("midrst_ready", bus.req_ready, 1'b1);
    check_counters("midrst");

    // Random references; enough of them to drive access_count into saturation.
    for (int n = 0; n < 20; n++) begin
      bus.set_hit = 4'($urandom_range(0, 15));
      for (int k = 0; k < NUM_SETS; k++)
        bus.set_rdata[k*64 +: 64] = {$urandom, $urandom};
      do_req($urandom, {$urandom, $urandom}, $urandom_range(0, 2));
    end
    check("sat_access", access_count, CMAX);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
